// File: rtl/burst_capture_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : burst_capture_ctrl_pkg
//  Description : Shared definitions for the burst capture controller and the
//                host-side checker. It holds the FSM state encoding and the
//                burst word width formula.
//  Revision    : 1.0  initial release
// ============================================================================
package burst_capture_ctrl_pkg;

  // Capture controller states. The explicit encoding is shared with the host-side checker.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SKIP    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  // Width of one burst word: (digits+1) signed digits per result, burst_index results.
  function automatic int calc_burst_width(input int nd, input int rb, input int bi);
    return (nd + 1) * rb * bi;
  endfunction

endpackage
`default_nettype wire

// File: rtl/burst_capture_ctrl_sdp_ram.sv
`default_nettype none
// ============================================================================
//  Module      : burst_capture_ctrl_sdp_ram
//  Description : Simple dual-port RAM, one write port and one registered read
//                port. Reset clears only the read register, never the array.
//  Revision    : 1.0  initial release
// ============================================================================
module burst_capture_ctrl_sdp_ram #(
  parameter int DATA_WIDTH = 216,
  parameter int ADDR_WIDTH = 14,
  parameter int DEPTH      = 16384
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Write port. The array has no reset so that it can map onto block RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read port. The output holds its value while no read is issued.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/burst_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : burst_capture_ctrl
//  Description : Samples one burst word every burst_index cycles. It discards
//                skip_bursts pipeline-fill bursts, then fills the capture RAM.
//                When the RAM is full it serves random-access readout.
//                Optional macro CAPTURE_CHECKSUM_EN enables a running XOR
//                checksum of the captured words. Without it, checksum is 0.
//  Revision    : 1.0  initial release
// ============================================================================
module burst_capture_ctrl
  import burst_capture_ctrl_pkg::*;
#(
  parameter int no_of_digits    = 8,
  parameter int radix_bits      = 3,
  parameter int burst_index     = 8,
  parameter int address_width   = 14,
  parameter int max_ram_address = 16384,
  parameter int skip_bursts     = 2,
  localparam int W = calc_burst_width(no_of_digits, radix_bits, burst_index)
) (
  input  logic                     ctrl_clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [W-1:0]             mem_in,
  input  logic                     rd_en,
  input  logic [address_width-1:0] rd_addr,
  output logic [W-1:0]             rd_data,
  output logic                     rd_valid,
  output logic                     busy,
  output logic                     done,
  output logic [address_width:0]   wr_count,
  output logic [W-1:0]             checksum
);

  localparam int PHW = (burst_index > 1) ? $clog2(burst_index) : 1;
  localparam int SKW = (skip_bursts > 1) ? $clog2(skip_bursts) : 1;
  localparam logic [PHW-1:0] PH_LAST = PHW'(burst_index - 1);
  localparam logic [SKW-1:0] SKIP_LAST = SKW'((skip_bursts > 0) ? skip_bursts - 1 : 0);
  localparam logic [address_width-1:0] ADDR_LAST = address_width'(max_ram_address - 1);
  // State entered from IDLE or DONE when start is accepted.
  localparam state_e RUN_ENTRY = (skip_bursts == 0) ? ST_CAPTURE : ST_SKIP;

  state_e                   state_q;
  logic [PHW-1:0]           phase_q;
  logic [SKW-1:0]           skip_cnt_q;
  logic [address_width-1:0] wr_addr_q;
  logic [address_width:0]   wr_count_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     rd_valid_q;

  logic boundary_d;
  logic start_accept_d;
  logic wr_en_d;
  logic rd_fire_d;

  // Decode burst boundaries, accepted starts, RAM writes and readout requests.
  always_comb begin
    boundary_d     = (phase_q == PH_LAST);
    start_accept_d = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    wr_en_d        = (state_q == ST_CAPTURE) && boundary_d;
    // A start in DONE takes priority and drops that cycle's read.
    rd_fire_d      = rd_en && (state_q == ST_DONE) && !start;
  end

  // Phase counter, FSM, write pointer and registered status outputs.
  always_ff @(posedge ctrl_clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      phase_q    <= '0;
      skip_cnt_q <= '0;
      wr_addr_q  <= '0;
      wr_count_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_fire_d;

      // Restart the phase at 0 on an accepted start so that burst boundaries align with it.
      if (start_accept_d) begin
        phase_q <= '0;
      end else if (boundary_d) begin
        phase_q <= '0;
      end else begin
        phase_q <= phase_q + PHW'(1);
      end

      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q    <= RUN_ENTRY;
            skip_cnt_q <= '0;
            wr_addr_q  <= '0;
            wr_count_q <= '0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
          end
        end
        ST_SKIP: begin
          if (boundary_d) begin
            if (skip_cnt_q == SKIP_LAST) begin
              state_q    <= ST_CAPTURE;
              skip_cnt_q <= '0;
            end else begin
              skip_cnt_q <= skip_cnt_q + SKW'(1);
            end
          end
        end
        ST_CAPTURE: begin
          if (wr_en_d) begin
            wr_addr_q  <= wr_addr_q + address_width'(1);
            wr_count_q <= wr_count_q + (address_width + 1)'(1);
            if (wr_addr_q == ADDR_LAST) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef CAPTURE_CHECKSUM_EN
  logic [W-1:0] checksum_q;

  // Running XOR of every word written during a run. It is cleared when a new run starts.
  always_ff @(posedge ctrl_clk) begin
    if (reset) begin
      checksum_q <= '0;
    end else if (start_accept_d) begin
      checksum_q <= '0;
    end else if (wr_en_d) begin
      checksum_q <= checksum_q ^ mem_in;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

  burst_capture_ctrl_sdp_ram #(
    .DATA_WIDTH (W),
    .ADDR_WIDTH (address_width),
    .DEPTH      (max_ram_address)
  ) u_ram (
    .clk_i   (ctrl_clk),
    .rst_i   (reset),
    .we_i    (wr_en_d),
    .waddr_i (wr_addr_q),
    .wdata_i (mem_in),
    .re_i    (rd_fire_d),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_valid = rd_valid_q;
  assign wr_count = wr_count_q;

endmodule
`default_nettype wire
